pi_uart_tx_arbiter: RTL
=======================

// Module: pi_uart_tx_arbiter
// PURPOSE
//  Shares the single Pi-header UART transmit line (gpio_i[15] path) between NUM_REQ on-chip byte sources.
//  Round-robin arbitration with packet-atomic grants, CTS flow control and built-in 8N1 serialisation.
//  Sits between the ZX-side peripherals (keyboard bridge, debug console, status reporter) and pi_led_sw_uart_i2s.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  CLKS_PER_BIT  243   clk_peripheral cycles per UART bit (28 MHz / 115200)
//  MAX_BURST     16    max bytes per grant before forced rotation (1..255)
//  HOLD_TIMEOUT  1024  idle cycles with granted valid low before grant is dropped
// PORTS
//  clk_peripheral  in   1            single clock, all logic
//  reset_n         in   1            asynchronous, active-low reset
//  req_valid       in   NUM_REQ      per-requester byte valid
//  req_data        in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//  req_last        in   NUM_REQ      byte is last of packet
//  req_ready       out  NUM_REQ      one-hot accept; transfer = valid & ready
//  uart_tx         out  1            serial line to Pi RX, idles high
//  uart_cts_n      in   1            Pi flow control, low = may send (async, synchronised inside)
//  grant_valid     out  1            a requester currently holds the line
//  grant_id        out  $clog2(NUM_REQ) index of holder (valid when grant_valid)
//  busy            out  1            serialiser mid-frame
// BEHAVIOUR
//  Reset (async assert, sync release): uart_tx=1, req_ready=0, grant_valid=0, grant_id=0, busy=0,
//   rr pointer = NUM_REQ-1 (requester 0 wins first tie), burst count=0, timeout count=0.
//  uart_cts_n through 2-flop synchroniser; cts_ok = synced value low.
//  FSM: IDLE -> (any req_valid) ARB -> GRANT; GRANT -> IDLE on release.
//   ARB (1 cycle): first set req_valid searching from (ptr+1) mod NUM_REQ upward, wrapping; latch grant_id,
//    ptr<=grant_id, grant_valid=1 from next cycle.
//  GRANT: req_ready[grant_id]=1 only when serialiser idle AND cts_ok AND req_valid[grant_id]; all others 0.
//   ready is combinational on those terms; never asserted for non-granted index.
//  Transfer at cycle N: byte captured, busy=1 and start bit on uart_tx from N+1.
//  Frame 8N1: start(0), d[0]..d[7] LSB first, stop(1); each bit exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT.
//   busy drops in the final stop-bit cycle so the next byte can transfer then: zero idle gap between back-to-back bytes.
//  Release: after transfer with req_last=1, or after MAX_BURST-th byte, or HOLD_TIMEOUT consecutive cycles
//   with req_valid[grant_id]=0. Release = grant_valid=0 next cycle, burst/timeout counters cleared; in-flight frame completes.
//  Timeout counter only counts while serialiser idle and cts_ok (CTS stall never drops a grant).
//  CTS deasserted mid-frame: current frame finishes; no new frame starts until cts_ok.
//  Requester dropping valid between bytes: holds grant until timeout (packet atomicity).
//  Simultaneous release and new requests: next ARB cycle immediately follows, rotation from new ptr.
//  Burst counter 8 bits, saturates never (cleared on release before reaching 255).
//  reset_n mid-frame: uart_tx forced high at once, frame discarded, all state to reset values.
// STRUCTURE
//  Package pi_uart_pkg: arb state enum {IDLE,ARB,GRANT}, UART_DATA_BITS=8, START_BIT=0, STOP_BIT=1.
//  Sub-module uart_tx_serial (load/data in, busy out, tx out; bit-period counter + 4-bit bit index).
//  Top: synchroniser, round-robin search (for-loop priority from ptr), FSM, burst/timeout counters.
// TESTING (CLKS_PER_BIT=4 for speed)
//  Single byte: req 0 sends 8'hA5 last=1, cts low -> uart_tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles; grant drops.
//  Round-robin: reqs 0,1,2 all valid 1-byte packets continuously -> grant order 0,1,2,0,1,2, no starvation.
//  Packet atomicity: req1 3-byte packet while req0 valid -> bytes 1a,1b,1c contiguous, then req0.
//  MAX_BURST=4, req2 streams 10 bytes last=0 with req3 waiting -> rotation to req3 after 4th byte.
//  CTS: cts_n high mid-frame -> frame completes, no next start until cts_n low + 2-cycle sync; grant kept.
//  Reset: reset_n low during data bit 3 -> uart_tx=1 same cycle, ready=0; after release req0 wins first.

Source files
------------

// File: rtl/pi_uart_pkg.sv
// Shared types and constants for the Pi-header UART transmit arbiter.
// Holds the arbiter state encoding, the 8N1 frame constants and a wrap helper.
package pi_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  // (ptr + off) mod n for off in 1..n, without a real divider.
  function automatic int rr_index(input int ptr, input int off, input int n);
    int s;
    s = ptr + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 serialiser: a load in an idle cycle starts the frame on the next cycle.
// Busy drops in the final stop-bit cycle so a following byte leaves no gap.
module uart_tx_serial
  import pi_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 243
) (
  input  logic                      clk_peripheral,
  input  logic                      reset_n,
  input  logic                      i_load,
  input  logic [UART_DATA_BITS-1:0] i_data,
  output logic                      o_busy,
  output logic                      o_tx
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     IDX_LAST = 4'(UART_FRAME_BITS - 1);

  logic                       r_active;
  logic [CW-1:0]              r_cnt;
  logic [3:0]                 r_idx;
  logic [UART_FRAME_BITS-1:0] r_frame;
  logic                       w_bit_end;
  logic                       w_frame_end;

  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_frame_end = r_active && w_bit_end && (r_idx == IDX_LAST);
  assign o_busy      = r_active && !w_frame_end;
  // Line is driven straight from a flop; an all-ones frame register means idle-high.
  assign o_tx        = r_frame[0];

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_frame  <= '1;
    end else if (i_load && !o_busy) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_frame  <= {STOP_BIT, i_data, START_BIT};
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_idx == IDX_LAST) begin
          r_active <= 1'b0;
          r_frame  <= '1;
        end else begin
          r_idx   <= r_idx + 4'd1;
          r_frame <= {STOP_BIT, r_frame[UART_FRAME_BITS-1:1]};
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi_uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART TX line between NUM_REQ byte sources,
// with CTS flow control and an embedded 8N1 serialiser.
module pi_uart_tx_arbiter
  import pi_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 243,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                       clk_peripheral,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx,
  input  logic                       uart_cts_n,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output arb_state_e                 dbg_state
);

  localparam int             IDW        = $clog2(NUM_REQ);
  localparam int             TW         = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [TW-1:0]  TO_LAST    = TW'(HOLD_TIMEOUT - 1);
  localparam logic [IDW-1:0] PTR_RESET  = IDW'(NUM_REQ - 1);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic           r_cts_meta;
  logic           r_cts_sync;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [7:0]     r_burst_cnt;
  logic [TW-1:0]  r_to_cnt;

  logic           w_cts_ok;
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic           w_granted;
  logic           w_gnt_valid;
  logic           w_gnt_last;
  logic [7:0]     w_gnt_data;
  logic           w_ser_busy;
  logic           w_xfer;
  logic           w_to_count;
  logic           w_to_expire;
  logic           w_release;

  // CTS is asynchronous to this clock; reset value means "not clear to send".
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= uart_cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = !r_cts_sync;

  // Round-robin: first requester with valid high, starting just after the last holder.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    v_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = IDW'(rr_index(int'(r_ptr), k, NUM_REQ));
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_gnt_valid = req_valid[i];
        w_gnt_last  = req_last[i];
        w_gnt_data  = req_data[8*i +: 8];
      end
    end
  end

  // Handshake: a byte moves in any cycle where req_valid[i] && req_ready[i].
  // Ready is combinational, one-hot, and only ever raised for the current holder.
  assign w_granted = (r_state == GRANT);
  assign w_xfer    = w_granted && !w_ser_busy && w_cts_ok && w_gnt_valid;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_xfer && (r_grant_id == IDW'(i))) req_ready[i] = 1'b1;
    end
  end

  // Idle time only accrues while the line could actually accept a byte, so a CTS stall never drops a grant.
  assign w_to_count  = w_granted && !w_ser_busy && w_cts_ok && !w_gnt_valid;
  assign w_to_expire = w_to_count && (r_to_cnt == TO_LAST);
  assign w_release   = w_granted &&
                       ((w_xfer && (w_gnt_last || (r_burst_cnt == BURST_LAST))) || w_to_expire);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_state_nxt = ARB;
      ARB:     w_state_nxt = w_found ? GRANT : IDLE;
      GRANT:   if (w_release) w_state_nxt = (|req_valid) ? ARB : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= PTR_RESET;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ARB) && w_found) begin
        r_grant_id <= w_winner;
        r_ptr      <= w_winner;
      end
      if (w_release || !w_granted) begin
        r_burst_cnt <= '0;
        r_to_cnt    <= '0;
      end else begin
        if (w_xfer) r_burst_cnt <= r_burst_cnt + 8'd1;
        if (w_gnt_valid)     r_to_cnt <= '0;
        else if (w_to_count) r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  uart_tx_serial #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serial (
    .clk_peripheral (clk_peripheral),
    .reset_n        (reset_n),
    .i_load         (w_xfer),
    .i_data         (w_gnt_data),
    .o_busy         (w_ser_busy),
    .o_tx           (uart_tx)
  );

  assign grant_valid = w_granted;
  assign grant_id    = r_grant_id;
  assign busy        = w_ser_busy;
  assign dbg_state   = r_state;

endmodule
